// File: rtl/mux_pkg.sv
// Shared constants for 2:1 mux users and the mux_2_arbiter front end.
// Select encoding, arbiter state encoding, source ids and default data width.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 1;

    localparam logic SEL_X1 = 1'b0;
    localparam logic SEL_X2 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef enum logic {
        SRC1 = 1'b0,
        SRC2 = 1'b1
    } src_e;

    function automatic logic src_to_sel(input src_e s);
        return (s == SRC2) ? SEL_X2 : SEL_X1;
    endfunction

endpackage

// File: rtl/rr_pick_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// source that did not win last.
module rr_pick_2
    import mux_pkg::*;
(
    input  logic req1,
    input  logic req2,
    input  src_e last_win,
    output src_e winner
);

    always_comb begin
        winner = SRC1;
        if (req1 && req2) begin
            winner = (last_win == SRC1) ? SRC2 : SRC1;
        end else if (req2) begin
            winner = SRC2;
        end
    end

endmodule

// File: rtl/mux_2_arbiter.sv
// Arbitrated 2:1 mux with a one-word registered output slot, valid/ready
// drain side, and per-source accept counters.
module mux_2_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req1,
    input  logic [WIDTH-1:0] x1,
    output logic             ack1,
    input  logic             req2,
    input  logic [WIDTH-1:0] x2,
    output logic             ack2,
    output logic             c,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2
);

    state_e           state_q, state_d;
    src_e             last_win_q, last_win_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic [7:0]       cnt1_q, cnt1_d;
    logic [7:0]       cnt2_q, cnt2_d;

    src_e winner;
    logic slot_free;
    logic load;

    rr_pick_2 u_pick (
        .req1     (req1),
        .req2     (req2),
        .last_win (last_win_q),
        .winner   (winner)
    );

    // rst_n gates load so no ack can escape while the block is held in reset.
    assign slot_free = (state_q == EMPTY) || y_ready;
    assign load      = rst_n && slot_free && (req1 || req2);
    assign ack1      = load && (winner == SRC1);
    assign ack2      = load && (winner == SRC2);

    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        y_d        = y_q;
        c_d        = c_q;
        cnt1_d     = cnt1_q;
        cnt2_d     = cnt2_q;
        if (load) begin
            state_d    = FULL;
            last_win_d = winner;
            y_d        = (winner == SRC2) ? x2 : x1;
            c_d        = src_to_sel(winner);
            if (winner == SRC1) begin
                cnt1_d = cnt1_q + 8'd1;
            end else begin
                cnt2_d = cnt2_q + 8'd1;
            end
        end else if (state_q == FULL && y_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            last_win_q <= SRC2;
            y_q        <= '0;
            c_q        <= SEL_X1;
            cnt1_q     <= 8'd0;
            cnt2_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
            y_q        <= y_d;
            c_q        <= c_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y       = y_q;
    assign c       = c_q;
    assign cnt1    = cnt1_q;
    assign cnt2    = cnt2_q;

endmodule

// File: tb/tb_mux_2_arbiter.sv
// Scoreboard bench for mux_2_arbiter: driver pushes expected words on each
// expected accept, monitor pops and compares on every output handshake.
module tb_mux_2_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req1, req2;
    logic [W-1:0] x1, x2;
    logic         ack1, ack2;
    logic         c;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic [7:0]   cnt1, cnt2;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    mux_2_arbiter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req1    (req1),
        .x1      (x1),
        .ack1    (ack1),
        .req2    (req2),
        .x2      (x2),
        .ack2    (ack2),
        .c       (c),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .cnt1    (cnt1),
        .cnt2    (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, record expected accepts, check acks mid-cycle.
    task automatic step(input logic r1, input logic [W-1:0] d1,
                        input logic r2, input logic [W-1:0] d2,
                        input logic rdy, input logic ea1, input logic ea2,
                        input string tag);
        @(posedge clk);
        #1;
        req1 = r1; x1 = d1; req2 = r2; x2 = d2; y_ready = rdy;
        if (ea1) exp_q.push_back('{y: d1, c: 1'b0});
        if (ea2) exp_q.push_back('{y: d2, c: 1'b1});
        @(negedge clk);
        chk({tag, "_ack1"}, 32'(ack1), 32'(ea1));
        chk({tag, "_ack2"}, 32'(ack2), 32'(ea2));
    endtask

    task automatic idle(input logic rdy, input string tag);
        step(1'b0, '0, 1'b0, '0, rdy, 1'b0, 1'b0, tag);
    endtask

    // Monitor: every delivered word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got y=%0h c=%0b with nothing expected", y, c);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (y !== e.y || c !== e.c) begin
                    errors++;
                    $display("FAIL mon_word: got y=%0h c=%0b expected y=%0h c=%0b at %0t",
                             y, c, e.y, e.c, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requests high
        rst_n = 1'b0; req1 = 1'b1; req2 = 1'b1; x1 = 8'h11; x2 = 8'h22; y_ready = 1'b1;
        @(negedge clk);
        chk("rst_ack1", 32'(ack1), 0);
        chk("rst_ack2", 32'(ack2), 0);
        chk("rst_yv", 32'(y_valid), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_cnt1", 32'(cnt1), 0);
        chk("rst_cnt2", 32'(cnt2), 0);
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0; rst_n = 1'b1;

        // Single source
        step(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "single");
        idle(1'b1, "single_out");
        chk("single_y", 32'(y), 32'h01);
        chk("single_yv", 32'(y_valid), 1);
        chk("single_c", 32'(c), 0);
        chk("single_cnt1", 32'(cnt1), 1);

        // Fresh reset so the tie starts from last_win=2
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst2_cnt1", 32'(cnt1), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie held 4 cycles: 1,2,1,2
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, "tie0");
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "tie1");
        chk("tie1_c", 32'(c), 0);
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, "tie2");
        chk("tie2_c", 32'(c), 1);
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, "tie3");
        chk("tie3_c", 32'(c), 0);
        idle(1'b1, "tie_out");
        chk("tie4_c", 32'(c), 1);
        chk("tie_cnt1", 32'(cnt1), 2);
        chk("tie_cnt2", 32'(cnt2), 2);

        // Backpressure
        step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "bp_load");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, "bp_hold");
            chk("bp_y", 32'(y), 32'h33);
            chk("bp_c", 32'(c), 0);
            chk("bp_yv", 32'(y_valid), 1);
        end
        step(1'b0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, "bp_release");
        idle(1'b1, "bp_out");
        chk("bp_new_y", 32'(y), 32'h44);
        chk("bp_new_c", 32'(c), 1);
        chk("bp_new_yv", 32'(y_valid), 1);

        // Mid-transfer reset
        step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "mid_load");
        idle(1'b0, "mid_hold");
        chk("mid_y_full", 32'(y), 32'h01);
        req1 = 1'b1; req2 = 1'b1;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_yv", 32'(y_valid), 0);
        chk("mid_y", 32'(y), 0);
        chk("mid_ack1", 32'(ack1), 0);
        chk("mid_ack2", 32'(ack2), 0);
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0; rst_n = 1'b1;
        step(1'b1, 8'h05, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0, "mid_tie");
        idle(1'b1, "mid_out");
        chk("mid_tie_y", 32'(y), 32'h05);
        chk("mid_tie_c", 32'(c), 0);
        chk("mid_cnt1", 32'(cnt1), 1);

        // Counter wrap on source 2
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'(i), 1'b1, 1'b0, 1'b1, "wrap");
        end
        idle(1'b1, "wrap_out");
        chk("wrap_cnt2", 32'(cnt2), 0);
        chk("wrap_cnt1", 32'(cnt1), 1);
        chk("wrap_y", 32'(y), 32'hFF);
        idle(1'b1, "drain");
        chk("drain_yv", 32'(y_valid), 0);
        chk("drain_q", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_2_arbiter.md
MUX_2_ARBITER -- requirements
Module: mux_2_arbiter

Interface
REQ-001 SHALL declare parameter WIDTH, default 1, giving the data width of each input and of the output.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state.
REQ-003 SHALL provide rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL provide req1 input 1, source 1 has a word on x1.
REQ-005 SHALL provide x1 input WIDTH, source 1 data, stable while req1=1.
REQ-006 SHALL provide ack1 output 1, one-cycle accept pulse for source 1.
REQ-007 SHALL provide req2, x2 and ack2, identical to req1, x1 and ack1 for source 2.
REQ-008 SHALL provide c output 1, registered select of the last accepted word (0=x1, 1=x2), usable directly as the select of a downstream 2:1 mux.
REQ-009 SHALL provide y output WIDTH, registered output word.
REQ-010 SHALL provide y_valid output 1, meaning y holds an undelivered word.
REQ-011 SHALL provide y_ready input 1, meaning the consumer takes y this cycle when y_valid=1.
REQ-012 SHALL provide cnt1 and cnt2 outputs 8, counting words accepted from each source.

Function
REQ-013 SHALL define slot_free = !y_valid || y_ready, and load = slot_free && (req1 || req2).
REQ-014 SHALL select the winner combinationally when load=1, as follows:
- only req1: winner 1.
- only req2: winner 2.
- both: the source other than last_win (round-robin).
REQ-015 SHALL drive ack1 = load && winner==1 and ack2 = load && winner==2, combinationally, and never both in the same cycle.
REQ-016 SHALL, at the clock edge where load=1, set y to the winner's data, y_valid to 1, c to the winner index, and last_win to the winner; latency is 1 cycle from ack to y_valid.
REQ-017 SHALL clear y_valid at the edge where y_valid && y_ready && !load; y and c hold their values.
REQ-018 SHALL hold y, c and y_valid unchanged while y_valid=1 and y_ready=0, regardless of requests, giving backpressure with no acks.
REQ-019 SHALL sustain one word per cycle when y_ready=1 continuously; a simultaneous drain and load replaces y without a bubble.
REQ-020 SHALL alternate winners every cycle when both sources hold their requests continuously; neither source waits more than 1 accept.
REQ-021 SHALL increment cnt1 or cnt2 by 1 at each accept from that source, wrapping from 255 to 0.
REQ-022 SHALL treat a source that keeps its request high after an ack as offering its next word; the source, not the block, changes x.
REQ-023 SHALL implement two states, EMPTY (y_valid=0) and FULL (y_valid=1), with these transitions:
- EMPTY to FULL on load.
- FULL to FULL on load, or on !y_ready.
- FULL to EMPTY on y_ready && !load.

Reset
REQ-024 SHALL, while rst_n=0, force y_valid=0, y=0, c=0, cnt1=0, cnt2=0, and last_win=2, so the first tie goes to source 1.
REQ-025 SHALL drive ack1=ack2=0 during reset, and discard a word held in FULL when rst_n asserts mid-transfer.
REQ-026 SHALL resume arbitration on the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL place the constants SEL_X1=0 and SEL_X2=1, the state encodings EMPTY and FULL, and the default WIDTH in a shared package mux_pkg, for use by both mux_2 users and this block.
REQ-028 SHALL factor the round-robin winner logic into one sub-module, rr_pick_2 (inputs req1, req2, last_win; output winner).

Verification
REQ-029 SHALL cover reset: rst_n=0 with req1=req2=1 -> ack1=ack2=0, y_valid=0, c=0, cnt1=cnt2=0.
REQ-030 SHALL cover a single source: req1=1, x1=1, y_ready=1 for 1 cycle -> ack1 in that cycle, then y=1, y_valid=1, c=0, cnt1=1 on the next edge.
REQ-031 SHALL cover a tie: req1=req2=1 held for 4 cycles with y_ready=1 -> acks in order 1,2,1,2, c sequence 0,1,0,1, and cnt1=cnt2=2.
REQ-032 SHALL cover backpressure: y_valid=1, y_ready=0 for 3 cycles with req2=1 -> ack2=0 and y, c stable; y_ready=1 -> ack2 in the same cycle and y replaced with no bubble.
REQ-033 SHALL cover mid-transfer reset: FULL with y=1, then rst_n pulsed low -> y_valid=0 and y=0 immediately; after release a tie grants source 1 first.
REQ-034 SHALL cover counter wrap: 256 accepts from source 2 -> cnt2=0 and cnt1 unchanged.
